// File: rtl/nihilist_pkg.sv
// Shared constants for the Nihilist (Polybius-square additive) cipher: square, key and code helper.
package nihilist_pkg;

   localparam logic [7:0] INVALID_CHAR = 8'h3F;
   localparam int         KEY_MAX      = 7;

   // Row-major 5x5 square; entry i sits at row i/5+1, column i%5+1.
   localparam logic [7:0] SQUARE [25] = '{
      "R", "A", "E", "S", "B",
      "C", "D", "F", "G", "H",
      "I", "K", "L", "M", "N",
      "O", "P", "Q", "T", "U",
      "V", "W", "X", "Y", "Z"
   };

   localparam logic [7:0] KEY_CHARS [KEY_MAX] = '{"N", "E", "D", "E", "L", "C", "U"};

   function automatic logic [7:0] code_of(input logic [7:0] ch);
      logic [7:0] code;
      code = 8'd0;
      for (int i = 0; i < 25; i++) begin
         if (SQUARE[i] == ch) code = 8'((i / 5 + 1) * 10 + (i % 5) + 1);
      end
      return code;
   endfunction

   localparam logic [7:0] KEY_CODE [KEY_MAX] = '{
      code_of(KEY_CHARS[0]), code_of(KEY_CHARS[1]), code_of(KEY_CHARS[2]),
      code_of(KEY_CHARS[3]), code_of(KEY_CHARS[4]), code_of(KEY_CHARS[5]),
      code_of(KEY_CHARS[6])
   };

endpackage

// File: rtl/polybius_unmap.sv
// Combinational map from a key-stripped row/column code back to its square letter.
module polybius_unmap
   import nihilist_pkg::*;
(
   input  logic [8:0] d_i,
   input  logic       underflow_i,
   output logic [7:0] char_o,
   output logic       err_o
);

   logic [8:0] row;
   logic [8:0] col;
   logic [4:0] idx;
   logic       ok;

   always_comb begin
      row    = d_i / 9'd10;
      col    = d_i % 9'd10;
      ok     = !underflow_i && (row >= 9'd1) && (row <= 9'd5) && (col >= 9'd1) && (col <= 9'd5);
      idx    = (5'(row[2:0]) - 5'd1) * 5'd5 + (5'(col[2:0]) - 5'd1);
      char_o = ok ? SQUARE[idx] : INVALID_CHAR;
      err_o  = !ok;
   end

endmodule

// File: rtl/nihilist_decryptor.sv
// Two-stage elastic decryptor: stage 1 strips the running key code, stage 2 maps the code to a letter.
module nihilist_decryptor
   import nihilist_pkg::*;
#(
   parameter int MSG_LEN = 16,
   parameter int SEC_LEN = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_data,
   output logic        out_err,
   output logic        out_last,
   output logic [15:0] err_cnt
);

   localparam int FW = $clog2(MSG_LEN + 1);

   logic          s1_vld_q, s1_vld_d, s1_uf_q, s1_last_q;
   logic [8:0]    s1_d_q;
   logic          s2_vld_q, s2_vld_d, s2_err_q, s2_last_q;
   logic [7:0]    s2_char_q;
   logic [2:0]    key_idx_q, key_idx_d;
   logic [FW-1:0] frame_q, frame_d;
   logic [15:0]   err_cnt_q, err_cnt_d;

   logic       in_fire, s2_load, out_fire, frame_end;
   logic [7:0] key;
   logic [7:0] unmap_char;
   logic       unmap_err;

   always_comb begin
      s2_load   = s1_vld_q && (!s2_vld_q || out_ready);
      in_ready  = !s1_vld_q || s2_load;
      in_fire   = in_valid && in_ready;
      out_fire  = s2_vld_q && out_ready;
      key       = KEY_CODE[key_idx_q];
      frame_end = (frame_q == FW'(MSG_LEN - 1));

      key_idx_d = key_idx_q;
      frame_d   = frame_q;
      if (in_fire) begin
         if (frame_end) begin
            key_idx_d = 3'd0;
            frame_d   = '0;
         end else begin
            key_idx_d = (key_idx_q == 3'(SEC_LEN - 1)) ? 3'd0 : key_idx_q + 3'd1;
            frame_d   = frame_q + 1'b1;
         end
      end

      // Stage 1 empties only when its byte moves on without a replacement arriving.
      s1_vld_d = in_fire ? 1'b1 : (s2_load ? 1'b0 : s1_vld_q);
      s2_vld_d = s2_load ? 1'b1 : (out_ready ? 1'b0 : s2_vld_q);

      err_cnt_d = err_cnt_q;
      if (out_fire && s2_err_q && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
   end

   polybius_unmap u_unmap (
      .d_i         (s1_d_q),
      .underflow_i (s1_uf_q),
      .char_o      (unmap_char),
      .err_o       (unmap_err)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld_q  <= 1'b0;
         s1_d_q    <= '0;
         s1_uf_q   <= 1'b0;
         s1_last_q <= 1'b0;
         s2_vld_q  <= 1'b0;
         s2_char_q <= '0;
         s2_err_q  <= 1'b0;
         s2_last_q <= 1'b0;
         key_idx_q <= '0;
         frame_q   <= '0;
         err_cnt_q <= '0;
      end else begin
         s1_vld_q  <= s1_vld_d;
         s2_vld_q  <= s2_vld_d;
         key_idx_q <= key_idx_d;
         frame_q   <= frame_d;
         err_cnt_q <= err_cnt_d;
         if (in_fire) begin
            s1_d_q    <= {1'b0, in_data} - {1'b0, key};
            s1_uf_q   <= (in_data < key);
            s1_last_q <= frame_end;
         end
         if (s2_load) begin
            s2_char_q <= unmap_char;
            s2_err_q  <= unmap_err;
            s2_last_q <= s1_last_q;
         end
      end
   end

   assign out_valid = s2_vld_q;
   assign out_data  = s2_char_q;
   assign out_err   = s2_err_q;
   assign out_last  = s2_last_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_nihilist_decryptor.sv
// Scoreboard bench: driver pushes expected plaintext from a letter-level model, monitor pops on output transfers.
module tb_nihilist_decryptor;

   localparam int MSG = 9;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_data = 8'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [7:0]  out_data;
   logic        out_err;
   logic        out_last;
   logic [15:0] err_cnt;

   nihilist_decryptor #(.MSG_LEN(MSG), .SEC_LEN(7)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_err(out_err), .out_last(out_last), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] ch;
      logic       err;
      logic       last;
   } exp_t;

   exp_t  sb[$];
   string SQ = "RAESBCDFGHIKLMNOPQTUVWXYZ";
   int    KEYS [7] = '{35, 13, 22, 13, 33, 21, 45};
   int    kidx = 0, fpos = 0, model_err = 0;
   int    n_cmp = 0, n_fail = 0;
   logic  held = 1'b0;
   exp_t  held_v;

   task automatic chk(input string nm, input int act, input int expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
      end
   endtask

   function automatic void model_reset();
      kidx = 0;
      fpos = 0;
      model_err = 0;
      sb.delete();
   endfunction

   // Decode an accepted cipher byte from the square's row/column arithmetic.
   function automatic void model_push(input logic [7:0] c);
      exp_t e;
      int   d, r, cc;
      d  = int'(c) - KEYS[kidx];
      r  = d / 10;
      cc = d % 10;
      e.last = (fpos == MSG - 1);
      if (d < 0 || r < 1 || r > 5 || cc < 1 || cc > 5) begin
         e.ch  = 8'h3F;
         e.err = 1'b1;
      end else begin
         e.ch  = SQ[(r - 1) * 5 + cc - 1];
         e.err = 1'b0;
      end
      sb.push_back(e);
      if (e.last) begin
         fpos = 0;
         kidx = 0;
      end else begin
         fpos++;
         kidx = (kidx + 1) % 7;
      end
   endfunction

   function automatic logic [7:0] enc(input logic [7:0] ch);
      int code = 0;
      for (int i = 0; i < 25; i++) if (SQ[i] == ch) code = (i / 5 + 1) * 10 + i % 5 + 1;
      return 8'(code + KEYS[kidx]);
   endfunction

   task automatic step(input logic v, input logic [7:0] d, input logic ordy, output logic acc);
      @(negedge clk);
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
      #1;
      acc = v && in_ready;
      if (acc) model_push(d);
      @(posedge clk);
   endtask

   task automatic send_str(input string s);
      logic acc;
      for (int i = 0; i < s.len(); i++) begin
         step(1'b1, enc(s[i]), 1'b1, acc);
         if (!acc) chk("send_accept", 0, 1);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic acc;
      step(1'b1, b, 1'b1, acc);
      if (!acc) chk("send_accept", 0, 1);
   endtask

   task automatic drain();
      logic acc;
      int   n = 0;
      while ((sb.size() != 0 || out_valid) && n < 30) begin
         step(1'b0, 8'd0, 1'b1, acc);
         n++;
      end
      chk("drain_empty", sb.size(), 0);
   endtask

   always @(negedge clk) begin
      #2;
      if (rst) begin
         held = 1'b0;
      end else begin
         if (held) begin
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_data", int'({out_data, out_err, out_last}), int'(held_v));
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_output", int'(out_data), -1);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("out_data", int'(out_data), int'(e.ch));
               chk("out_err", int'(out_err), int'(e.err));
               chk("out_last", int'(out_last), int'(e.last));
               if (e.err) model_err++;
            end
         end
         held   = out_valid && !out_ready;
         held_v = '{out_data, out_err, out_last};
      end
   end

   initial begin
      logic acc;
      int   nacc;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_err", int'(out_err), 0);
      chk("rst_out_last", int'(out_last), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_err_cnt", int'(err_cnt), 0);
      @(negedge clk);
      rst = 1'b0;

      // Two back-to-back frames must decode identically (key restarts at frame start).
      send_str("HELLOWORD");
      send_str("HELLOWORD");
      send_str("AAAAAAAAA");
      drain();
      chk("err_cnt_clean", int'(err_cnt), 0);

      // One undecodable byte at the head of each frame.
      send_byte(8'd5);  send_str("AAAAAAAA");
      send_byte(8'd41); send_str("AAAAAAAA");
      send_byte(8'd95); send_str("AAAAAAAA");
      drain();
      chk("err_cnt_three", int'(err_cnt), 3);
      chk("err_cnt_model", int'(err_cnt), model_err);

      // Downstream stall with continuous input: only two bytes fit.
      nacc = 0;
      for (int i = 0; i < 5; i++) begin
         step(1'b1, enc("T"), 1'b0, acc);
         if (acc) nacc++;
         if (i >= 2) chk("stall_in_ready", int'(acc), 0);
      end
      chk("stall_accepted", nacc, 2);
      send_str("EST");
      drain();

      // Asynchronous reset between edges in the middle of a frame.
      send_str("HELL");
      @(posedge clk);
      #3;
      rst = 1'b1;
      in_valid = 1'b0;
      #1;
      chk("arst_out_valid", int'(out_valid), 0);
      chk("arst_out_data", int'(out_data), 0);
      chk("arst_in_ready", int'(in_ready), 1);
      chk("arst_err_cnt", int'(err_cnt), 0);
      model_reset();
      @(negedge clk);
      #4;
      rst = 1'b0;
      send_str("HELLOWORD");
      drain();

      // Random traffic: mix of valid letters and raw bytes with random backpressure.
      for (int i = 0; i < 800; i++) begin
         logic [7:0] b;
         if ($urandom_range(1, 0) == 1) b = enc(SQ[$urandom_range(24, 0)]);
         else b = 8'($urandom_range(255, 0));
         step(($urandom_range(3, 0) != 0), b, ($urandom_range(3, 0) != 0), acc);
      end
      drain();
      chk("err_cnt_final", int'(err_cnt), model_err);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
